irq_ctrl_6502: RTL

Memory-mapped interrupt controller sitting directly upstream of `cpu_6502`: it collects eight asynchronous peripheral interrupt sources, latches their rising edges, masks them and drives the CPU `IRQ` input. It is a bus slave on the CPU's synchronous memory bus (`AB`/`DO`/`WE`/`RDY`) and returns read data with the same registered one-cycle latency as system RAM. Its data output is muxed into `DI` by the top-level address decoder.

---
 rtl/irq_ctrl_pkg.sv | 28 ++
 rtl/irq_sync_edge.sv | 32 +++
 rtl/irq_ctrl_6502.sv | 99 +++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the irq_ctrl_6502 interrupt controller.
// The VECTOR priority encoder is only used when IRQ_CTRL_VECTOR_EN is defined.
package irq_ctrl_pkg;

  localparam int unsigned NUM_SRC = 8;

  localparam logic [1:0] IRQ_OFS_PEND   = 2'd0;
  localparam logic [1:0] IRQ_OFS_MASK   = 2'd1;
  localparam logic [1:0] IRQ_OFS_ACTIVE = 2'd2;
  localparam logic [1:0] IRQ_OFS_VECTOR = 2'd3;

  localparam logic [7:0] PEND_RST  = 8'h00;
  localparam logic [7:0] MASK_RST  = 8'h00;
  localparam logic [7:0] RDATA_RST = 8'h00;
  localparam logic       IRQ_RST   = 1'b0;
  localparam logic       SEL_RST   = 1'b0;

  // Lowest-numbered active bit wins; result is {any_active, 4'b0, idx}.
  function automatic logic [7:0] vector_enc(input logic [NUM_SRC-1:0] act);
    logic [7:0] v;
    v = 8'h00;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (act[i]) v = {1'b1, 4'b0000, i[2:0]};
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: 2-flop synchronizer, history flop and rising-edge pulse.
module irq_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, hist_q;
  logic vld_q, armed_q;

  // armed_q requires a low sample after reset, so a source held high through
  // reset never produces an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      vld_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      vld_q   <= 1'b1;
      armed_q <= armed_q | (vld_q & ~sync1_q);
    end
  end

  assign pulse_o = sync2_q & ~hist_q & armed_q;

endmodule

// File: rtl/irq_ctrl_6502.sv
// Memory-mapped 8-source edge-latched interrupt controller for cpu_6502.
// Define IRQ_CTRL_VECTOR_EN to build the VECTOR priority encoder.
module irq_ctrl_6502
  import irq_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        ab,
  input  logic [7:0]         dout,
  input  logic               we,
  input  logic               rdy,
  output logic [7:0]         rdata,
  output logic               sel_q,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq
);

  logic [NUM_SRC-1:0] edge_pulse;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] w1c, w1s;
  logic [7:0]         vector;
  logic [7:0]         rd_mux;
  logic [7:0]         rdata_q;
  logic               irq_q;
  logic               hit, wr_en;
  logic [1:0]         ofs;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk_i   (clk),
      .rst_i   (rst),
      .src_i   (src[g]),
      .pulse_o (edge_pulse[g])
    );
  end

  assign hit    = (ab[15:2] == BASE_ADDR[15:2]);
  assign ofs    = ab[1:0];
  assign wr_en  = we & rdy & hit;
  assign active = pend_q & mask_q;

`ifdef IRQ_CTRL_VECTOR_EN
  assign vector = vector_enc(active);
`else
  assign vector = 8'h00;
`endif

  always_comb begin
    mask_d = mask_q;
    w1c    = '0;
    w1s    = '0;
    if (wr_en) begin
      case (ofs)
        IRQ_OFS_PEND:   w1c    = dout;
        IRQ_OFS_MASK:   mask_d = dout;
        IRQ_OFS_ACTIVE: w1s    = dout;
        default:        ;
      endcase
    end
    // Hardware edges are OR-ed in last so they win over a same-cycle clear.
    pend_d = (pend_q & ~w1c) | w1s | edge_pulse;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (ofs)
      IRQ_OFS_PEND:   rd_mux = pend_q;
      IRQ_OFS_MASK:   rd_mux = mask_q;
      IRQ_OFS_ACTIVE: rd_mux = active;
      default:        rd_mux = vector;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= PEND_RST;
      mask_q  <= MASK_RST;
      irq_q   <= IRQ_RST;
      rdata_q <= RDATA_RST;
      sel_q   <= SEL_RST;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      irq_q  <= |active;
      if (rdy) begin
        sel_q <= hit;
        if (hit) rdata_q <= rd_mux;
      end
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
